// File: rtl/ext_trig_rx_if.sv
// Result bundle of the external trigger receiver: capture start, measurements,
// status flags and the receiver state for observation.
interface ext_trig_rx_if #(
  parameter int CNT_W = 20,
  parameter int PW_W  = 12
);
  // o_st and o_meas_valid are single-cycle strobes with no ready/back-pressure;
  // o_period/o_pulse are stable from the o_meas_valid cycle until the next one.
  logic             o_st;
  logic [CNT_W-1:0] o_period;
  logic [PW_W-1:0]  o_pulse;
  logic             o_meas_valid;
  logic             o_overrun;
  logic             o_timeout;
  logic [15:0]      o_trig_cnt;
  logic [1:0]       o_dbg_state;

  modport master (
    output o_st, o_period, o_pulse, o_meas_valid,
    output o_overrun, o_timeout, o_trig_cnt, o_dbg_state
  );

  modport slave (
    input o_st, o_period, o_pulse, o_meas_valid,
    input o_overrun, o_timeout, o_trig_cnt, o_dbg_state
  );
endinterface

// File: rtl/ext_trig_rx.sv
// External trigger receiver: synchronise, glitch-filter and polarise the trigger
// line, issue a one-cycle capture start and measure trigger period and width.
module ext_trig_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int CNT_W       = 20,
  parameter int PW_W        = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_negedge,
  input  logic             i_trig,
  input  logic [CNT_W-1:0] i_holdoff,
  ext_trig_rx_if.master    meas
);

  localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PW_W-1:0]  PW_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ACTIVE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FC_W-1:0]        filt_cnt_q;
  logic                   filt_q;
  logic                   lvl_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   samp;

  assign samp = sync_q[SYNC_STAGES-1] ^ i_negedge;

  // Edge pulses are registered one cycle after the filter flips, so rise_q
  // always coincides with lvl_q already showing the new level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q     <= '0;
      filt_cnt_q <= '0;
      filt_q     <= 1'b0;
      lvl_q      <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_trig};
      if (samp == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FC_W'(FILT_LEN - 1)) begin
        filt_q     <= samp;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FC_W'(1);
      end
      lvl_q  <= filt_q;
      rise_q <= filt_q & ~lvl_q;
      fall_q <= ~filt_q & lvl_q;
    end
  end

  state_t           state_q, state_d;
  logic             st_q, st_d;
  logic             mv_q, mv_d;
  logic [15:0]      trig_cnt_q, trig_cnt_d;
  logic [PW_W-1:0]  width_q, width_d;
  logic [PW_W-1:0]  pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cap_q, cap_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             prior_q, prior_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic             holdoff_ok;

  assign holdoff_ok = (cnt_q >= i_holdoff);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      st_q       <= 1'b0;
      mv_q       <= 1'b0;
      trig_cnt_q <= '0;
      width_q    <= '0;
      pulse_q    <= '0;
      cnt_q      <= '0;
      cap_q      <= '0;
      period_q   <= '0;
      prior_q    <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      st_q       <= st_d;
      mv_q       <= mv_d;
      trig_cnt_q <= trig_cnt_d;
      width_q    <= width_d;
      pulse_q    <= pulse_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      period_q   <= period_d;
      prior_q    <= prior_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    st_d       = 1'b0;
    mv_d       = 1'b0;
    trig_cnt_d = trig_cnt_q;
    width_d    = width_q;
    pulse_d    = pulse_q;
    cap_d      = cap_q;
    period_d   = period_q;
    prior_d    = prior_q;
    overrun_d  = overrun_q;
    timeout_d  = timeout_q;
    cnt_d      = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    if (cnt_q == CNT_MAX) timeout_d = 1'b1;

    if (!i_en) begin
      state_d    = S_IDLE;
      trig_cnt_d = '0;
      cnt_d      = '0;
      prior_d    = 1'b0;
      overrun_d  = 1'b0;
      timeout_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!lvl_q) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (rise_q) begin
            st_d       = 1'b1;
            trig_cnt_d = trig_cnt_q + 16'd1;
            width_d    = PW_W'(1);
            cnt_d      = '0;
            timeout_d  = 1'b0;
            // Interval between this start and the previous one, i.e. cnt_q + 1.
            if (prior_q) cap_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
            else         cap_d = '0;
            prior_d    = 1'b1;
            state_d    = S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          width_d = (width_q == PW_MAX) ? PW_MAX : width_q + PW_W'(1);
          if (fall_q) begin
            pulse_d  = width_q;
            period_d = cap_q;
            mv_d     = 1'b1;
            state_d  = holdoff_ok ? S_ARMED : S_HOLD;
          end
        end
        S_HOLD: begin
          if (rise_q)          overrun_d = 1'b1;
          else if (holdoff_ok) state_d   = S_ARMED;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign meas.o_st         = st_q;
  assign meas.o_period     = period_q;
  assign meas.o_pulse      = pulse_q;
  assign meas.o_meas_valid = mv_q;
  assign meas.o_overrun    = overrun_q;
  assign meas.o_timeout    = timeout_q;
  assign meas.o_trig_cnt   = trig_cnt_q;
  assign meas.o_dbg_state  = state_q;

endmodule
